insn_queue: RTL and testbench

- Instruction prefetch FIFO placed between insn_fetcher and insn_decoder.
- Decouples fetch from decode back-pressure: accepts fetched instructions together with their instruction addresses and presents them in order to the decoder.
- Uses the same valid/stall pipeline handshake as the other stages.
- Supports a synchronous flush, used on branch redirect, that discards all queued instructions.

---
 rtl/insn_queue.sv | 100 ++++++++++
 tb/tb_insn_queue.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/insn_queue.sv
// Instruction prefetch FIFO between fetcher and decoder: valid/stall handshake,
// registered-only outputs, synchronous flush for branch redirect, stall statistics.
module insn_queue #(
  parameter int LEN_INSN      = 32,
  parameter int MEM_INSN_ADDR = 16,
  parameter int DEPTH         = 4,
  parameter int LOG2_DEPTH    = 2,
  parameter int LEN_STATCNT   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_i,
  input  logic                     valid_i,
  output logic                     stall_o,
  input  logic [LEN_INSN-1:0]      insn_i,
  input  logic [MEM_INSN_ADDR-1:0] addr_i,
  output logic                     valid_o,
  input  logic                     stall_i,
  output logic [LEN_INSN-1:0]      insn_o,
  output logic [MEM_INSN_ADDR-1:0] addr_o,
  output logic [LOG2_DEPTH:0]      count_o,
  output logic [LEN_STATCNT-1:0]   stall_cycles_o
);

  typedef struct packed {
    logic [LEN_INSN-1:0]      insn;
    logic [MEM_INSN_ADDR-1:0] addr;
  } entry_t;

  entry_t [DEPTH-1:0]     mem_q, mem_d;
  logic [LOG2_DEPTH-1:0]  wr_ptr_q, wr_ptr_d;
  logic [LOG2_DEPTH-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LOG2_DEPTH:0]    count_q, count_d;
  logic [LEN_STATCNT-1:0] stall_cycles_q, stall_cycles_d;
  logic                   push, pop;
  entry_t                 head;

  // Outputs depend only on registered state; full is judged on count alone,
  // so a pop in the same cycle never opens a slot for a push.
  always_comb begin
    valid_o        = (count_q != '0);
    stall_o        = (count_q == (LOG2_DEPTH+1)'(DEPTH));
    head           = mem_q[rd_ptr_q];
    insn_o         = valid_o ? head.insn : '0;
    addr_o         = valid_o ? head.addr : '0;
    count_o        = count_q;
    stall_cycles_o = stall_cycles_q;
  end

  always_comb begin
    push           = valid_i && !stall_o && !flush_i;
    pop            = valid_o && !stall_i && !flush_i;
    mem_d          = mem_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    count_d        = count_q;
    stall_cycles_d = stall_cycles_q;

    if (push) begin
      mem_d[wr_ptr_q] = {insn_i, addr_i};
      wr_ptr_d        = wr_ptr_q + LOG2_DEPTH'(1);
    end
    if (pop)
      rd_ptr_d = rd_ptr_q + LOG2_DEPTH'(1);

    case ({push, pop})
      2'b10:   count_d = count_q + (LOG2_DEPTH+1)'(1);
      2'b01:   count_d = count_q - (LOG2_DEPTH+1)'(1);
      default: count_d = count_q;
    endcase

    // Redirect: everything queued is dropped; the write pointer stays put.
    if (flush_i) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end

    if (valid_i && stall_o && (stall_cycles_q != '1))
      stall_cycles_d = stall_cycles_q + LEN_STATCNT'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      stall_cycles_q <= '0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  // Storage needs no reset; stale slots are masked by count.
  always_ff @(posedge clk)
    mem_q <= mem_d;

endmodule

// File: tb/tb_insn_queue.sv
// Scoreboard bench for insn_queue: directed stimulus, a queue-based reference
// fed at each edge, and a negedge monitor comparing every presented output.
module tb_insn_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, flush_i, valid_i, stall_i;
  logic [31:0] insn_i;
  logic [15:0] addr_i;
  logic        stall_o, valid_o;
  logic [31:0] insn_o;
  logic [15:0] addr_o;
  logic [2:0]  count_o;
  logic [15:0] stall_cycles_o;

  int n_tests = 0;
  int n_fail  = 0;
  bit mon_en  = 1'b0;

  typedef struct packed {
    logic [31:0] insn;
    logic [15:0] addr;
  } ent_t;

  ent_t        exp_q[$];
  logic [15:0] exp_stall = '0;

  insn_queue dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .valid_i(valid_i), .stall_o(stall_o), .insn_i(insn_i), .addr_i(addr_i),
    .valid_o(valid_o), .stall_i(stall_i), .insn_o(insn_o), .addr_o(addr_o),
    .count_o(count_o), .stall_cycles_o(stall_cycles_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: push entries the queue must accept, pop on downstream transfer.
  always @(posedge clk) begin
    bit full, push, pop;
    full = (exp_q.size() == DEPTH);
    push = valid_i && !full && !flush_i;
    pop  = (exp_q.size() != 0) && !stall_i && !flush_i;
    if (rst) begin
      exp_q.delete();
      exp_stall = '0;
    end else begin
      if (valid_i && full && exp_stall != 16'hFFFF) exp_stall++;
      if (flush_i) exp_q.delete();
      else begin
        if (pop)  void'(exp_q.pop_front());
        if (push) exp_q.push_back('{insn: insn_i, addr: addr_i});
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      chk("mon_valid", {31'b0, valid_o}, {31'b0, exp_q.size() != 0});
      chk("mon_stall", {31'b0, stall_o}, {31'b0, exp_q.size() == DEPTH});
      chk("mon_count", {29'b0, count_o}, exp_q.size());
      chk("mon_statcnt", {16'b0, stall_cycles_o}, {16'b0, exp_stall});
      if (exp_q.size() != 0) begin
        chk("mon_insn", insn_o, exp_q[0].insn);
        chk("mon_addr", {16'b0, addr_o}, {16'b0, exp_q[0].addr});
      end else begin
        chk("mon_insn_idle", insn_o, 32'h0);
        chk("mon_addr_idle", {16'b0, addr_o}, 32'h0);
      end
    end
  end

  task automatic step(input logic v, input logic [31:0] ins, input logic [15:0] ad,
                      input logic si, input logic fl, input logic r);
    valid_i = v; insn_i = ins; addr_i = ad; stall_i = si; flush_i = fl; rst = r;
    @(posedge clk);
    #1;
  endtask

  bit seen_40;
  always @(negedge clk)
    if (mon_en && valid_o && addr_o == 16'h0040) seen_40 = 1'b1;

  initial begin
    rst = 1'b1; flush_i = 0; valid_i = 0; stall_i = 0; insn_i = '0; addr_i = '0;
    seen_40 = 1'b0;
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    chk("rst_count", {29'b0, count_o}, 0);
    chk("rst_valid", {31'b0, valid_o}, 0);
    chk("rst_stall", {31'b0, stall_o}, 0);
    chk("rst_statcnt", {16'b0, stall_cycles_o}, 0);
    mon_en = 1'b1;

    // Single push, visible next cycle
    step(1, 32'h11111111, 16'h0000, 1, 0, 0);
    chk("t1_valid", {31'b0, valid_o}, 1);
    chk("t1_insn", insn_o, 32'h11111111);
    chk("t1_addr", {16'b0, addr_o}, 0);
    chk("t1_count", {29'b0, count_o}, 1);
    step(0, 0, 0, 0, 0, 0);
    chk("t1_drained", {31'b0, valid_o}, 0);

    // Fill, reject fifth, drain in order
    for (int i = 0; i < 4; i++) step(1, 32'hA0000000 + i, 16'(i), 1, 0, 0);
    chk("t2_count", {29'b0, count_o}, 4);
    chk("t2_stall", {31'b0, stall_o}, 1);
    step(1, 32'hA0000004, 16'h0004, 1, 0, 0);
    chk("t2_statcnt", {16'b0, stall_cycles_o}, 1);
    chk("t2_count_held", {29'b0, count_o}, 4);
    for (int i = 0; i < 4; i++) begin
      chk("t2_order", {16'b0, addr_o}, i);
      step(0, 0, 0, 0, 0, 0);
    end
    chk("t2_empty", {31'b0, valid_o}, 0);

    // Streaming through, pointers wrap
    for (int i = 0; i < 10; i++) begin
      step(1, 32'hC0000000 + i, 16'(i), 0, 0, 0);
      chk("t3_count", {29'b0, count_o}, 1);
      chk("t3_addr", {16'b0, addr_o}, i);
      chk("t3_insn", insn_o, 32'hC0000000 + i);
    end
    step(0, 0, 0, 0, 0, 0);
    chk("t3_empty", {31'b0, valid_o}, 0);

    // Flush with a concurrent push
    for (int i = 0; i < 3; i++) step(1, 32'hD0000000 + i, 16'h0010 + 16'(i), 1, 0, 0);
    chk("t4_count3", {29'b0, count_o}, 3);
    step(1, 32'hD0000040, 16'h0040, 1, 1, 0);
    chk("t4_count", {29'b0, count_o}, 0);
    chk("t4_valid", {31'b0, valid_o}, 0);
    chk("t4_insn", insn_o, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("t4_never_40", {31'b0, seen_40}, 0);
    chk("t4_statcnt", {16'b0, stall_cycles_o}, 1);

    // Full: pop without push, then push and pop together
    for (int i = 0; i < 4; i++) step(1, 32'hE0000000 + i, 16'h0020 + 16'(i), 1, 0, 0);
    step(1, 32'hE0000004, 16'h0024, 0, 0, 0);
    chk("t5_count_pop", {29'b0, count_o}, 3);
    chk("t5_head1", {16'b0, addr_o}, 32'h0021);
    step(1, 32'hE0000004, 16'h0024, 0, 0, 0);
    chk("t5_count_both", {29'b0, count_o}, 3);
    chk("t5_head2", {16'b0, addr_o}, 32'h0022);
    chk("t5_statcnt", {16'b0, stall_cycles_o}, 2);

    // Mid-operation reset, then saturate the statistics counter
    step(0, 0, 0, 0, 0, 0);
    chk("t6_count2", {29'b0, count_o}, 2);
    step(1, 32'hF0000000, 16'h0030, 1, 0, 1);
    chk("t6_count", {29'b0, count_o}, 0);
    chk("t6_valid", {31'b0, valid_o}, 0);
    chk("t6_stall", {31'b0, stall_o}, 0);
    chk("t6_statcnt", {16'b0, stall_cycles_o}, 0);
    for (int i = 0; i < 4; i++) step(1, 32'hF0000000 + i, 16'h0030 + 16'(i), 1, 0, 0);
    chk("t6_full", {31'b0, stall_o}, 1);
    for (int i = 0; i < 65536 + 5; i++) step(1, 32'hF0000009, 16'h0039, 1, 0, 0);
    chk("t6_saturated", {16'b0, stall_cycles_o}, 32'h0000FFFF);
    chk("t6_count_full", {29'b0, count_o}, 4);
    chk("t6_head", {16'b0, addr_o}, 32'h0030);

    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
